// File: rtl/dcram_bist_ctl.sv
// dcram_bist_ctl
// March C- BIST sequencer for the two 32-bit data-cache RAM banks.
// It drives the shared BIST address, the write strobe, the write-data polarity
// and the compare strobe used by the per-bank pattern/compare blocks. It also
// folds their mismatch flags into sticky error and done status.
//
// Optional feature macro: DCRAM_BIST_STOP_ON_FAIL_EN
//   defined   : the first masked mismatch ends the run (DONE on that edge)
//   undefined : the full march always runs; fail_* keeps the first failure
//
// Ports
//   clk         core clock
//   reset_l     asynchronous active-low reset
//   bist_start  start pulse, honoured in IDLE or DONE
//   bist_abort  synchronous return to IDLE (beats bist_start)
//   bist_mode   bank select latched at start: 00/11 both, 01 bank0, 10 bank1
//   bank_err    per-bank mismatch from local BIST, qualified by cmp_en
//   bist_on     RAM input muxes select the BIST path
//   bist_addr   word address
//   bist_we     write strobe for the enabled banks
//   bank_en     per-bank enable, constant during a run
//   inverse     write data polarity (1 = all ones)
//   cmp_en      compare strobe for the read issued in the previous cycle
//   cmp_inv     expected polarity of that read
//   done        run complete, held
//   error       sticky mismatch on any enabled bank
//   fail_addr   address of the first failing read
//   fail_elem   march element of the first failing read
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for bist_start, BIST path released
// RUN   | stepping through march elements M0..M5, one op per cycle
// DRAIN | last read issued, its compare strobe is out this cycle
// DONE  | status held until the next start, abort or reset

module dcram_bist_ctl #(
    parameter int ADDR_W = 11,
    parameter int NELEM  = 6
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              bist_start,
    input  logic              bist_abort,
    input  logic [1:0]        bist_mode,
    input  logic [1:0]        bank_err,
    output logic              bist_on,
    output logic [ADDR_W-1:0] bist_addr,
    output logic              bist_we,
    output logic [1:0]        bank_en,
    output logic              inverse,
    output logic              cmp_en,
    output logic              cmp_inv,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [2:0]        ELEM_LAST = 3'(NELEM - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [2:0]        r_elem;
    logic [ADDR_W-1:0] r_addr;
    logic              r_phase;      // 0 = read slot, 1 = write slot of the address
    logic [1:0]        r_bank_en;
    logic              r_cmp_en;
    logic              r_cmp_inv;
    logic [ADDR_W-1:0] r_cmp_addr;
    logic [2:0]        r_cmp_elem;
    logic              r_done;
    logic              r_error;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [2:0]        r_fail_elem;

    logic w_start;
    logic w_dir_up;
    logic w_op_wr;
    logic w_op_rd;
    logic w_wr_val;
    logic w_rd_val;
    logic w_addr_done;
    logic w_last_addr;
    logic w_march_end;
    logic w_next_up;
    logic w_mismatch;
    logic w_first_fail;
    logic w_stop;

    always_comb begin
        w_start     = bist_start && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_dir_up    = (r_elem < 3'd3);
        // M0 has no read, so its phase bit is ignored and every op is a write.
        w_op_wr     = (r_elem == 3'd0) || r_phase;
        w_op_rd     = !w_op_wr;
        w_wr_val    = r_elem[0];
        w_rd_val    = (r_elem == 3'd2) || (r_elem == 3'd4);
        // M5 is read-only, so its read also finishes the address.
        w_addr_done = w_op_wr || (r_elem == ELEM_LAST);
        w_last_addr = w_dir_up ? (r_addr == ADDR_MAX) : (r_addr == '0);
        w_march_end = (r_elem == ELEM_LAST) && w_last_addr && w_addr_done;
        w_next_up   = (r_elem == 3'd0) || (r_elem == 3'd1);
        w_mismatch  = r_cmp_en && ((bank_err & r_bank_en) != 2'b00);
        w_first_fail = w_mismatch && !r_error;
`ifdef DCRAM_BIST_STOP_ON_FAIL_EN
        w_stop      = w_first_fail;
`else
        w_stop      = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        bist_on      = 1'b0;
        bist_we      = 1'b0;
        inverse      = 1'b0;
        if (bist_abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bist_start) w_next_state = S_RUN;
                end
                S_RUN: begin
                    if (w_stop)           w_next_state = S_DONE;
                    else if (w_march_end) w_next_state = S_DRAIN;
                end
                S_DRAIN: w_next_state = S_DONE;
                default: w_next_state = S_IDLE;
            endcase
        end
        if ((r_state == S_RUN) || (r_state == S_DRAIN)) bist_on = 1'b1;
        if (r_state == S_RUN) begin
            bist_we = w_op_wr;
            inverse = w_op_wr && w_wr_val;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_elem      <= 3'd0;
            r_addr      <= '0;
            r_phase     <= 1'b0;
            r_bank_en   <= 2'b00;
            r_cmp_en    <= 1'b0;
            r_cmp_inv   <= 1'b0;
            r_cmp_addr  <= '0;
            r_cmp_elem  <= 3'd0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= 3'd0;
        end else if (bist_abort) begin
            // Abort drops the run but keeps the failure record for debug.
            r_done   <= 1'b0;
            r_cmp_en <= 1'b0;
        end else begin
            r_cmp_en <= (r_state == S_RUN) && w_op_rd && !w_stop;
            if ((r_state == S_RUN) && w_op_rd) begin
                r_cmp_inv  <= w_rd_val;
                r_cmp_addr <= r_addr;
                r_cmp_elem <= r_elem;
            end
            if (w_start) begin
                case (bist_mode)
                    2'b01:   r_bank_en <= 2'b01;
                    2'b10:   r_bank_en <= 2'b10;
                    default: r_bank_en <= 2'b11;
                endcase
                r_error     <= 1'b0;
                r_fail_addr <= '0;
                r_fail_elem <= 3'd0;
                r_done      <= 1'b0;
                r_elem      <= 3'd0;
                r_addr      <= '0;
                r_phase     <= 1'b0;
            end else begin
                if (w_first_fail) begin
                    r_error     <= 1'b1;
                    r_fail_addr <= r_cmp_addr;
                    r_fail_elem <= r_cmp_elem;
                end
                if ((r_state == S_DRAIN) || ((r_state == S_RUN) && w_stop)) begin
                    r_done <= 1'b1;
                end
                if ((r_state == S_RUN) && !w_stop) begin
                    if (w_addr_done) begin
                        r_phase <= 1'b0;
                        if (w_last_addr) begin
                            if (!w_march_end) begin
                                r_elem <= r_elem + 3'd1;
                                r_addr <= w_next_up ? '0 : ADDR_MAX;
                            end
                        end else begin
                            r_addr <= w_dir_up ? (r_addr + ADDR_ONE) : (r_addr - ADDR_ONE);
                        end
                    end else begin
                        r_phase <= 1'b1;
                    end
                end
            end
        end
    end

    assign bist_addr = r_addr;
    assign bank_en   = r_bank_en;
    assign cmp_en    = r_cmp_en;
    assign cmp_inv   = r_cmp_inv;
    assign done      = r_done;
    assign error     = r_error;
    assign fail_addr = r_fail_addr;
    assign fail_elem = r_fail_elem;

endmodule

// File: tb/tb_dcram_bist_ctl.sv
// Testbench for dcram_bist_ctl (ADDR_W = 3, N = 8 words per bank).
// The expected op stream, compare stream and end-of-run status are computed
// from the March C- element table and pushed into queues; a monitor pops
// them whenever the DUT shows an op, a compare strobe or a rising done.

module tb_dcram_bist_ctl;

    localparam int AW   = 3;
    localparam int N    = 1 << AW;
    localparam int NR   = 5 * N;
    localparam int NOPS = 10 * N;
`ifdef DCRAM_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    // March C- element table, index 0 = M0 ... 5 = M5
    localparam bit [0:5] HAS_RD = 6'b011111;
    localparam bit [0:5] RD_V   = 6'b001010;
    localparam bit [0:5] HAS_WR = 6'b111110;
    localparam bit [0:5] WR_V   = 6'b010100;

    logic          clk;
    logic          reset_l;
    logic          bist_start;
    logic          bist_abort;
    logic [1:0]    bist_mode;
    logic [1:0]    bank_err;
    logic          bist_on;
    logic [AW-1:0] bist_addr;
    logic          bist_we;
    logic [1:0]    bank_en;
    logic          inverse;
    logic          cmp_en;
    logic          cmp_inv;
    logic          done;
    logic          error;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;

    dcram_bist_ctl #(.ADDR_W(AW), .NELEM(6)) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .bist_start (bist_start),
        .bist_abort (bist_abort),
        .bist_mode  (bist_mode),
        .bank_err   (bank_err),
        .bist_on    (bist_on),
        .bist_addr  (bist_addr),
        .bist_we    (bist_we),
        .bank_en    (bank_en),
        .inverse    (inverse),
        .cmp_en     (cmp_en),
        .cmp_inv    (cmp_inv),
        .done       (done),
        .error      (error),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic          inv;
    } op_t;

    typedef struct {
        logic          err;
        logic [AW-1:0] fa;
        logic [2:0]    fe;
        logic [1:0]    ben;
        int            dcyc;
    } st_t;

    op_t  q_op[$];
    logic q_cmp[$];
    st_t  q_st[$];

    logic [1:0] plan [NR];
    bit         rand_idle = 1'b1;
    logic [1:0] idle_err  = 2'b00;
    int         start_cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // bank_err driver: the k-th compare of a run gets plan[k]; between
    // compares the lines carry junk that must be ignored.
    int rd_idx = 0;
    always @(negedge clk) begin
        if (bist_start && !bist_on) rd_idx = 0;
        if (cmp_en) begin
            bank_err = (rd_idx < NR) ? plan[rd_idx] : 2'b00;
            rd_idx++;
        end else begin
            bank_err = rand_idle ? 2'($urandom) : idle_err;
        end
    end

    // Monitor / scoreboard
    logic done_prev = 1'b0;
    always @(negedge clk) begin : mon
        op_t  o;
        st_t  s;
        logic e;
        int   rel;
        rel = cyc - start_cyc + 1;
        if (bist_on && (q_op.size() > 0)) begin
            o = q_op.pop_front();
            check("op_addr", 32'(bist_addr), 32'(o.addr));
            check("op_we", 32'(bist_we), 32'(o.we));
            check("op_inverse", 32'(inverse), 32'(o.inv));
        end
        if (cmp_en) begin
            check("cmp_expected", 32'(q_cmp.size() != 0), 32'd1);
            if (q_cmp.size() != 0) begin
                e = q_cmp.pop_front();
                check("cmp_inv", 32'(cmp_inv), 32'(e));
            end
        end
        if (done && !done_prev) begin
            done_cnt++;
            check("status_expected", 32'(q_st.size() != 0), 32'd1);
            if (q_st.size() != 0) begin
                s = q_st.pop_front();
                check("done_cycle", 32'(rel), 32'(s.dcyc));
                check("error", 32'(error), 32'(s.err));
                check("fail_addr", 32'(fail_addr), 32'(s.fa));
                check("fail_elem", 32'(fail_elem), 32'(s.fe));
                check("bank_en", 32'(bank_en), 32'(s.ben));
                check("ops_left", 32'(q_op.size()), 32'd0);
                check("cmps_left", 32'(q_cmp.size()), 32'd0);
                check("done_quiet", 32'({bist_on, bist_we, cmp_en}), 32'd0);
            end
        end
        done_prev = done;
    end

    // Reference model: walk the element table address by address.
    task automatic build_model(input logic [1:0] mode);
        logic [1:0]    ben;
        logic [AW-1:0] a;
        int            j, k, fail_j, lim_op, lim_cmp;
        st_t           s;
        op_t           o;
        ben    = (mode == 2'b01) ? 2'b01 : (mode == 2'b10) ? 2'b10 : 2'b11;
        s.err  = 1'b0;
        s.fa   = '0;
        s.fe   = 3'd0;
        s.ben  = ben;
        fail_j = -1;
        lim_op = NOPS;
        lim_cmp = NOPS;
        for (int pass = 0; pass < 2; pass++) begin
            j = 0;
            k = 0;
            for (int el = 0; el < 6; el++) begin
                for (int i = 0; i < N; i++) begin
                    a = (el < 3) ? AW'(i) : AW'(N - 1 - i);
                    if (HAS_RD[el]) begin
                        j++;
                        if (pass == 0) begin
                            if ((fail_j < 0) && ((plan[k] & ben) != 2'b00)) begin
                                fail_j = j;
                                s.err  = 1'b1;
                                s.fa   = a;
                                s.fe   = 3'(el);
                            end
                        end else begin
                            if (j <= lim_op) begin
                                o.addr = a; o.we = 1'b0; o.inv = 1'b0;
                                q_op.push_back(o);
                            end
                            if (j <= lim_cmp) q_cmp.push_back(RD_V[el]);
                        end
                        k++;
                    end
                    if (HAS_WR[el]) begin
                        j++;
                        if ((pass == 1) && (j <= lim_op)) begin
                            o.addr = a; o.we = 1'b1; o.inv = WR_V[el];
                            q_op.push_back(o);
                        end
                    end
                end
            end
            if ((pass == 0) && STOP && (fail_j >= 0)) begin
                lim_op  = fail_j + 1;
                lim_cmp = fail_j;
            end
        end
        s.dcyc = (STOP && (fail_j >= 0)) ? fail_j + 2 : NOPS + 2;
        q_st.push_back(s);
    endtask

    task automatic flush();
        q_op.delete();
        q_cmp.delete();
        q_st.delete();
    endtask

    task automatic clear_plan(input logic [1:0] v);
        for (int i = 0; i < NR; i++) plan[i] = v;
    endtask

    task automatic do_run(input logic [1:0] mode, input int abort_at, input int rst_at, input int pulse_at);
        int  dc0;
        int  rel;
        bit  fin;
        bit  saw_done;
        st_t s;
        build_model(mode);
        s   = q_st[$];
        dc0 = done_cnt;
        @(posedge clk); #1;
        bist_mode  = mode;
        bist_start = 1'b1;
        @(posedge clk); #1;
        start_cyc  = cyc;
        bist_start = 1'b0;
        fin = 1'b0;
        for (int t = 0; (t < NOPS + 50) && !fin; t++) begin
            @(negedge clk); #1;
            rel = cyc - start_cyc + 1;
            bist_start = (rel == pulse_at);
            bist_abort = (abort_at > 0) && (rel == abort_at);
            if ((abort_at > 0) && (rel == abort_at + 1)) begin
                check("abort_bist_on", 32'(bist_on), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                check("abort_we_cmp", 32'({bist_we, cmp_en}), 32'd0);
                check("abort_error_kept", 32'(error), 32'(s.err));
                check("abort_fail_kept", 32'({fail_addr, fail_elem}), 32'({s.fa, s.fe}));
                flush();
                fin = 1'b1;
            end else if ((rst_at > 0) && (rel == rst_at)) begin
                reset_l = 1'b0;
                #1;
                check("async_reset_outs",
                      32'({bist_on, bist_addr, bist_we, bank_en, inverse, cmp_en,
                           cmp_inv, done, error, fail_addr, fail_elem}), 32'd0);
                flush();
                repeat (2) @(negedge clk);
                reset_l  = 1'b1;
                saw_done = 1'b0;
                repeat (NOPS + 10) begin
                    @(negedge clk);
                    if (done || bist_on) saw_done = 1'b1;
                end
                check("no_run_after_reset", 32'(saw_done), 32'd0);
                fin = 1'b1;
            end else if ((done_cnt != dc0) && (abort_at == 0) && (rst_at == 0)) begin
                fin = 1'b1;
            end
        end
        check("run_finished", 32'(fin), 32'd1);
        bist_start = 1'b0;
        bist_abort = 1'b0;
    endtask

    initial begin
        reset_l    = 1'b0;
        bist_start = 1'b0;
        bist_abort = 1'b0;
        bist_mode  = 2'b00;
        clear_plan(2'b00);
        #12;
        check("reset_outs",
              32'({bist_on, bist_addr, bist_we, bank_en, inverse, cmp_en,
                   cmp_inv, done, error, fail_addr, fail_elem}), 32'd0);
        @(negedge clk);
        reset_l = 1'b1;
        repeat (2) @(posedge clk);

        // clean full march, both banks
        clear_plan(2'b00);
        do_run(2'b00, 0, 0, 0);

        // bank1 mismatch on the M2 read of address 5 only
        clear_plan(2'b00);
        plan[N + 5] = 2'b10;
        do_run(2'b00, 0, 0, 0);

        // bank0 only, bank1 flag held high throughout -> masked
        rand_idle = 1'b0;
        idle_err  = 2'b10;
        clear_plan(2'b10);
        do_run(2'b01, 0, 0, 0);
        rand_idle = 1'b1;

        // randomized modes and sparse mismatch patterns
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < NR; i++)
                plan[i] = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            do_run(2'($urandom), 0, 0, 0);
        end

        // abort at cycle 20 after an early M1 failure, then a fresh clean run
        clear_plan(2'b00);
        plan[0] = 2'b01;
        do_run(2'b00, 20, 0, 0);
        clear_plan(2'b00);
        do_run(2'b00, 0, 0, 0);

        // asynchronous reset in the middle of a run
        do_run(2'b11, 0, 30, 0);

        // start pulse during a run is ignored
        do_run(2'b10, 0, 0, 40);

        // DONE status holds
        repeat (4) @(negedge clk);
        check("done_hold", 32'({done, error, bist_on}), 32'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
